// File: rtl/m31_pkg.sv
// Shared types and constants for Mersenne-31 (P = 2^31-1) modular arithmetic.
package m31_pkg;

  localparam logic [30:0] P_M31 = 31'h7FFF_FFFF;

  typedef logic [30:0] m31_t;

  // Operation select for the subtract pipeline.
  typedef enum logic [1:0] {
    SUB  = 2'd0,  // A - B
    RSUB = 2'd1,  // B - A
    NEG  = 2'd2,  // -A
    PASS = 2'd3   // A
  } m31_subop_t;

  // Fold a 32-bit sum into canonical [0, P-1]: add the end-around carry,
  // then the only non-canonical value left is P itself, which maps to 0.
  function automatic m31_t m31_fold(input logic [31:0] raw);
    m31_t folded;
    folded = raw[30:0] + {30'd0, raw[31]};
    return (folded == P_M31) ? '0 : folded;
  endfunction

endpackage

// File: rtl/m31_sub_pipe_if.sv
// Upstream operation port and downstream result port of the M31 subtract pipe.
// Handshake: a transfer happens on a port at a rising clk edge where valid and
// ready are both high; valid never waits on ready, and an offered item with its
// data stays unchanged until it transfers.
interface m31_sub_pipe_if #(
  parameter int TAG_W = 8
) ();
  import m31_pkg::*;

  logic             in_valid;
  logic             in_ready;
  m31_t             a_i;
  m31_t             b_i;
  m31_subop_t       op_i;
  logic [TAG_W-1:0] tag_i;

  logic             out_valid;
  logic             out_ready;
  m31_t             res_o;
  logic [TAG_W-1:0] tag_o;

  // Side that offers operations and consumes results.
  modport master (
    output in_valid, a_i, b_i, op_i, tag_i, out_ready,
    input  in_ready, out_valid, res_o, tag_o
  );

  // The pipeline itself.
  modport slave (
    input  in_valid, a_i, b_i, op_i, tag_i, out_ready,
    output in_ready, out_valid, res_o, tag_o
  );
endinterface

// File: rtl/m31_pipe_stage.sv
// One valid/ready register slice: a valid flag plus a data register.
// Ready depends only on this slice's own valid and the downstream ready, so
// there is no combinational path from in_valid to in_ready.
module m31_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic load;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  // Data moves only on a load; valid drops when drained without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/m31_sub_pipe.sv
// Two-stage modular subtractor over GF(2^31-1) with an opaque sideband tag.
// Stage 1 selects operands and registers x + (P - y) as a 32-bit sum;
// stage 2 folds that sum into canonical [0, P-1].
module m31_sub_pipe
  import m31_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  m31_sub_pipe_if.slave  bus
);

  localparam int S1_W = 32 + TAG_W;
  localparam int S2_W = 31 + TAG_W;

  m31_t             x;
  m31_t             y;
  logic [31:0]      raw_in;
  logic [S1_W-1:0]  s1_in_data;
  logic [S1_W-1:0]  s1_data;
  logic             s1_valid;
  logic             s2_ready;
  logic [31:0]      s1_raw;
  logic [TAG_W-1:0] s1_tag;
  logic [S2_W-1:0]  s2_in_data;
  logic [S2_W-1:0]  s2_data;

  // Operand select; P - y is the 31-bit complement of y, so an input of P
  // behaves exactly like 0 once the sum is folded.
  always_comb begin
    x = bus.a_i;
    y = bus.b_i;
    case (bus.op_i)
      SUB:  begin x = bus.a_i; y = bus.b_i; end
      RSUB: begin x = bus.b_i; y = bus.a_i; end
      NEG:  begin x = '0;      y = bus.a_i; end
      PASS: begin x = bus.a_i; y = '0;      end
    endcase
  end

  assign raw_in     = {1'b0, x} + {1'b0, ~y};
  assign s1_in_data = {raw_in, bus.tag_i};

  m31_pipe_stage #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign s1_raw     = s1_data[TAG_W +: 32];
  assign s1_tag     = s1_data[TAG_W-1:0];
  assign s2_in_data = {m31_fold(s1_raw), s1_tag};

  m31_pipe_stage #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_data)
  );

  assign bus.res_o = s2_data[TAG_W +: 31];
  assign bus.tag_o = s2_data[TAG_W-1:0];

endmodule

// File: tb/tb_m31_sub_pipe.sv
// Bench for m31_sub_pipe: directed corner cases, a stall stream, a mid-flight
// reset and a long random run against an arithmetic reference model.
module tb_m31_sub_pipe;
  import m31_pkg::*;

  localparam int TAG_W = 8;
  localparam int EW    = 32 + TAG_W + 31;  // {accept cycle, tag, result}
  localparam longint P = 64'd2147483647;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  m31_sub_pipe_if #(.TAG_W(TAG_W)) bus ();

  m31_sub_pipe #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  lat_chk  = 1'b0;
  bit  stall_seen = 1'b0;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain modular arithmetic on integers.
  function automatic m31_t ref_sub(input m31_t a, input m31_t b, input m31_subop_t op);
    longint xa, xb, x, y, r;
    xa = longint'(a) % P;
    xb = longint'(b) % P;
    case (op)
      SUB:     begin x = xa; y = xb; end
      RSUB:    begin x = xb; y = xa; end
      NEG:     begin x = 0;  y = xa; end
      default: begin x = xa; y = 0;  end
    endcase
    r = (((x - y) % P) + P) % P;
    return m31_t'(r);
  endfunction

  function automatic m31_t rnd_m31();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return P_M31;
      2:       return 31'd1;
      3:       return P_M31 - 31'd1;
      default: return m31_t'($urandom) & P_M31;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One cycle: drive at the falling edge, then check the ready rule from the
  // current pipeline occupancy and record an accepted operation.
  task automatic drive_cycle(input bit v, input m31_t a, input m31_t b, input m31_subop_t op,
                             input logic [TAG_W-1:0] tag, input bit ordy, input m31_t exp_res,
                             output bit acc);
    int occ;
    @(negedge clk);
    bus.in_valid  = v;
    bus.a_i       = a;
    bus.b_i       = b;
    bus.op_i      = op;
    bus.tag_i     = tag;
    bus.out_ready = ordy;
    #1;
    occ = exp_q.size();
    chk("in_ready_rule", bus.in_ready == ((occ < 2) || ordy), bus.in_ready, (occ < 2) || ordy);
    if (!bus.in_ready) stall_seen = 1'b1;
    acc = v && bus.in_ready;
    if (acc) exp_q.push_back({cyc[31:0], tag, exp_res});
  endtask

  task automatic send(input m31_t a, input m31_t b, input m31_subop_t op,
                      input logic [TAG_W-1:0] tag, input m31_t exp_res);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) drive_cycle(1'b1, a, b, op, tag, 1'b1, exp_res, acc);
    if (!acc) chk("send_timeout", 1'b0, 0, 1);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, SUB, '0, ordy, '0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1, 1'b1);
    chk("drain_empty", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  bit   prev_stall = 1'b0;
  m31_t prev_res;
  logic [TAG_W-1:0] prev_tag;

  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", bus.out_valid == 1'b1, bus.out_valid, 1);
          chk("hold_res", bus.res_o == prev_res, bus.res_o, prev_res);
          chk("hold_tag", bus.tag_o == prev_tag, bus.tag_o, prev_tag);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_res   = bus.res_o;
        prev_tag   = bus.tag_o;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1'b0, bus.res_o, 0);
          end else begin
            e = exp_q.pop_front();
            chk("res", bus.res_o == e[30:0], bus.res_o, e[30:0]);
            chk("tag", bus.tag_o == e[31 +: TAG_W], bus.tag_o, e[31 +: TAG_W]);
            if (lat_chk)
              chk("latency", (cyc - int'(e[EW-1 -: 32])) == 2, cyc - int'(e[EW-1 -: 32]), 2);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    int k;
    m31_t a, b;
    m31_subop_t op;

    bus.in_valid  = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    bus.op_i      = SUB;
    bus.tag_i     = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
    chk("rst_res", bus.res_o == '0, bus.res_o, 0);
    chk("rst_tag", bus.tag_o == '0, bus.tag_o, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases, back to back with out_ready high: latency 2.
    lat_chk = 1'b1;
    send(31'd5, 31'd3, SUB, 8'hA5, 31'd2);
    send(31'd3, 31'd5, SUB, 8'h01, 31'd2147483645);
    send(31'd1, 31'd0, NEG, 8'h02, 31'd2147483646);
    send(31'd0, 31'd0, NEG, 8'h03, 31'd0);
    send(P_M31, 31'd0, SUB, 8'h04, 31'd0);
    send(31'd0, P_M31, SUB, 8'h05, 31'd0);
    send(P_M31, 31'd9, PASS, 8'h06, 31'd0);
    send(31'd0, 31'd7, RSUB, 8'h07, 31'd7);
    send(31'd12, 31'd4, PASS, 8'h08, 31'd12);
    drain();
    lat_chk = 1'b0;

    // Stream of 8 ops, out_ready low in cycles 3..6 of the stream.
    stall_seen = 1'b0;
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      a  = rnd_m31();
      b  = rnd_m31();
      op = m31_subop_t'($urandom_range(0, 3));
      drive_cycle(1'b1, a, b, op, TAG_W'(k), !(c >= 3 && c <= 6), ref_sub(a, b, op), acc);
      if (acc) k++;
    end
    chk("stream_all_sent", k == 8, k, 8);
    chk("stream_stalled", stall_seen == 1'b1, stall_seen, 1);
    drain();

    // Reset with two operations in flight.
    send(31'd100, 31'd1, SUB, 8'h11, 31'd99);
    drive_cycle(1'b1, 31'd200, 31'd2, SUB, 8'h12, 1'b0, 31'd198, acc);
    chk("rst_setup_acc", acc == 1'b1, acc, 1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6, 1'b1);
    chk("no_stale_out", bus.out_valid == 1'b0, bus.out_valid, 0);

    // Random operations with random backpressure.
    for (int c = 0; c < 20000; c++) begin
      a  = rnd_m31();
      b  = rnd_m31();
      op = m31_subop_t'($urandom_range(0, 3));
      drive_cycle($urandom_range(0, 3) != 0, a, b, op, TAG_W'($urandom),
                  $urandom_range(0, 3) != 0, ref_sub(a, b, op), acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
